// File: rtl/king_move_scanner_if.sv
//==============================================================================
// king_move_scanner_if -- move-select and board-RAM signals of the king scanner
// Rev 1.0 | optional captureMask under KING_CAPTURE_MASK_EN
//==============================================================================
`default_nettype none

interface king_move_scanner_if #(
  parameter int SQ_W = 5
);
  logic            start;
  logic [2:0]      row;
  logic [2:0]      column;
  logic            color;
  logic            busy;
  logic            done;
  logic [7:0]      kingAllow;
  logic            rd_en;
  logic [2:0]      rd_row;
  logic [2:0]      rd_col;
  logic [SQ_W-1:0] rd_data;
`ifdef KING_CAPTURE_MASK_EN
  logic [7:0]      captureMask;

  modport master (
    output start, row, column, color, rd_data,
    input  busy, done, kingAllow, rd_en, rd_row, rd_col, captureMask
  );
  modport slave (
    input  start, row, column, color, rd_data,
    output busy, done, kingAllow, rd_en, rd_row, rd_col, captureMask
  );
`else
  modport master (
    output start, row, column, color, rd_data,
    input  busy, done, kingAllow, rd_en, rd_row, rd_col
  );
  modport slave (
    input  start, row, column, color, rd_data,
    output busy, done, kingAllow, rd_en, rd_row, rd_col
  );
`endif
endinterface

`default_nettype wire

// File: rtl/king_move_scanner.sv
//==============================================================================
// king_move_scanner -- builds the king move mask by scanning 8 neighbours through
// one shared board read port. Rev 1.0 | macro KING_CAPTURE_MASK_EN adds captureMask
//==============================================================================
`default_nettype none

module king_move_scanner #(
  parameter int NUM_DIRS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  king_move_scanner_if.slave bus
);

  localparam logic [2:0] LAST_DIR = 3'(NUM_DIRS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic [2:0] dir;
  logic [2:0] k_row;
  logic [2:0] k_col;
  logic       k_color;
  logic       pend_valid;
  logic [2:0] pend_dir;
  logic [7:0] allow;
  logic       go_up, go_down, go_right, go_left;
  logic       off_board;
  logic [2:0] tgt_row;
  logic [2:0] tgt_col;
  logic       rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SCAN;
          accept    = 1'b1;
        end
      end
      SCAN:    if (dir == 3'd0) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edges are excluded before the wrapping 3-bit +/-1 target arithmetic is used.
  always_comb begin
    go_up     = (dir == 3'd7) || (dir == 3'd6) || (dir == 3'd0);
    go_down   = (dir == 3'd4) || (dir == 3'd3) || (dir == 3'd2);
    go_right  = (dir == 3'd6) || (dir == 3'd5) || (dir == 3'd4);
    go_left   = (dir == 3'd2) || (dir == 3'd1) || (dir == 3'd0);
    off_board = (go_up && k_row == 3'd0) || (go_down && k_row == 3'd7) ||
                (go_right && k_col == 3'd7) || (go_left && k_col == 3'd0);
    tgt_row = k_row;
    if (go_up)        tgt_row = k_row - 3'd1;
    else if (go_down) tgt_row = k_row + 3'd1;
    tgt_col = k_col;
    if (go_right)     tgt_col = k_col + 3'd1;
    else if (go_left) tgt_col = k_col - 3'd1;
  end

  assign rd_en         = (state == SCAN) && !off_board;
  assign bus.rd_en     = rd_en;
  assign bus.rd_row    = rd_en ? tgt_row : 3'd0;
  assign bus.rd_col    = rd_en ? tgt_col : 3'd0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.kingAllow = allow;

`ifdef KING_CAPTURE_MASK_EN
  logic [7:0] capture;
  assign bus.captureMask = capture;
`endif

  // Read data for the previous SCAN cycle's direction arrives one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir        <= LAST_DIR;
      k_row      <= 3'd0;
      k_col      <= 3'd0;
      k_color    <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= 3'd0;
      allow      <= 8'd0;
`ifdef KING_CAPTURE_MASK_EN
      capture    <= 8'd0;
`endif
    end else begin
      pend_valid <= rd_en;
      pend_dir   <= dir;
      if (accept) begin
        k_row   <= bus.row;
        k_col   <= bus.column;
        k_color <= bus.color;
        dir     <= LAST_DIR;
        allow   <= 8'd0;
`ifdef KING_CAPTURE_MASK_EN
        capture <= 8'd0;
`endif
      end else if (state == SCAN) begin
        dir <= dir - 3'd1;
      end
      if (pend_valid) begin
        allow[pend_dir] <= (bus.rd_data[1:0] != {k_color, 1'b1});
`ifdef KING_CAPTURE_MASK_EN
        capture[pend_dir] <= bus.rd_data[0] && (bus.rd_data[1] != k_color);
`endif
      end
    end
  end

endmodule

`default_nettype wire
